// File: rtl/dual_debounce_pkg.sv
// Shared project constants for the dual switch debouncer.
//
// Holds the default debounce depth and synchronizer depth used by the top
// level and the per-channel debouncer. The package also provides the helper
// that sizes the stability counter, so every file derives it the same way.
package dual_debounce_pkg;

  // Consecutive stable synchronized samples required before a level change.
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  // Flops in each raw-input synchronizer chain.
  localparam int SYNC_STAGES_DEF = 2;

  // Counter width able to hold 0..cycles.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/dual_debounce_if.sv
// Signal bundle between the dual debouncer and its surroundings.
//
// Signals:
//   A_raw, B_raw   : asynchronous raw switch/button levels (into the debouncer)
//   A, B           : debounced levels
//   A_rise, A_fall : one-cycle pulses on A 0->1 / 1->0
//   B_rise, B_fall : one-cycle pulses on B 0->1 / 1->0
// Modports:
//   master : the side that owns the switches and consumes the debounced levels
//   slave  : the debouncer itself
interface dual_debounce_if;
  import dual_debounce_pkg::*;

  logic A_raw;
  logic B_raw;
  logic A;
  logic B;
  logic A_rise;
  logic A_fall;
  logic B_rise;
  logic B_fall;

  modport master (
    output A_raw, B_raw,
    input  A, B, A_rise, A_fall, B_rise, B_fall
  );

  modport slave (
    input  A_raw, B_raw,
    output A, B, A_rise, A_fall, B_rise, B_fall
  );

endinterface

// File: rtl/dual_debounce_channel.sv
// Single-channel switch debouncer.
//
// The raw input passes through a SYNC_STAGES-deep synchronizer. The output
// level follows the synchronized value only after DEBOUNCE_CYCLES
// consecutive samples disagree with the current level. A rise/fall pulse is
// registered alongside the level change, so the pulse appears in the same
// cycle the level first shows its new value.
//
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (clears synchronizer, counter,
//           level and pulses)
//   raw   : asynchronous raw input
//   level : debounced level
//   rise  : one-cycle pulse on level 0->1
//   fall  : one-cycle pulse on level 1->0
module debounce_channel
  import dual_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

  // The counter value seen on the edge that completes a full mismatch run.
  // Updating on this edge (instead of letting the count reach
  // DEBOUNCE_CYCLES) keeps the counter from ever holding or wrapping past it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic [CNT_W-1:0]       cnt;
  logic                   synced;

  assign synced = sync_chain[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_chain <= '0;
      cnt        <= '0;
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
    end else begin
      // Stage boundary: raw input enters the synchronizer chain.
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};

      // Stage boundary: stability counter and level update.
      rise <= 1'b0;
      fall <= 1'b0;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= synced;
        cnt   <= '0;
        rise  <= synced;
        fall  <= ~synced;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dual_debounce.sv
// Two independent switch debouncers sharing one clock.
//
// Channel A and channel B are identical debounce_channel instances; nothing
// is shared between them except clk and rst, so simultaneous raw changes on
// both channels update both outputs on the same edge.
//
// Ports:
//   clk : rising-edge clock, the only clock in the block
//   rst : synchronous active-high reset
//   io  : dual_debounce_if.slave bundle
//         (A_raw, B_raw in; A, B, A_rise, A_fall, B_rise, B_fall out)
module dual_debounce
  import dual_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input logic           clk,
  input logic           rst,
  dual_debounce_if.slave io
);

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_chan_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (io.A_raw),
    .level (io.A),
    .rise  (io.A_rise),
    .fall  (io.A_fall)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_chan_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (io.B_raw),
    .level (io.B),
    .rise  (io.B_rise),
    .fall  (io.B_fall)
  );

endmodule

// File: doc/dual_debounce.md
DUAL_DEBOUNCE -- requirements
Module: dual_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples needed before an output changes; legal range >= 1.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth per channel; legal range >= 2.
REQ-003 Port clk  input  1  single clock, rising-edge active; the only clock in the block.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port A_raw  input  1  asynchronous raw switch/button, channel A.
REQ-006 Port B_raw  input  1  asynchronous raw switch/button, channel B.
REQ-007 Port A  output  1  debounced level, channel A; drives gate input A.
REQ-008 Port B  output  1  debounced level, channel B; drives gate input B.
REQ-009 Port A_rise / A_fall  output  1 each  one-cycle pulses on A 0->1 / 1->0.
REQ-010 Port B_rise / B_fall  output  1 each  one-cycle pulses on B 0->1 / 1->0.

Function
REQ-011 Each channel SHALL pass its raw input through SYNC_STAGES flops, clocked on clk, before any other use.
REQ-012 Each channel SHALL keep a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-013 The counter SHALL increment on every edge where the synchronized value differs from the debounced output.
REQ-014 The counter SHALL clear on any edge where the synchronized value equals the output.
REQ-015 On the edge where the count reaches DEBOUNCE_CYCLES, the output SHALL take the synchronized value and the counter SHALL clear.
REQ-016 Latency: a raw change held stable SHALL appear on the output exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after first sampling (6 edges at defaults).
REQ-017 Any mismatch run shorter than DEBOUNCE_CYCLES SHALL leave the output unchanged and raise no pulse.
REQ-018 Rise/fall pulses SHALL be registered, high for exactly one cycle, and asserted in the same cycle the output first shows its new value.
REQ-019 Rise and fall of one channel SHALL never be high together.
REQ-020 Channels SHALL be fully independent; simultaneous changes on both SHALL update both outputs on the same edge.
REQ-021 Counter SHALL never wrap: it is cleared on reaching DEBOUNCE_CYCLES.

Reset
REQ-022 While rst=1, on each edge: synchronizer flops, counters, A, B and all pulse outputs SHALL go to 0.
REQ-023 Reset mid-count SHALL discard the partial count; after release a held-high raw input SHALL need the full REQ-016 latency.
REQ-024 No pulse SHALL be generated by reset itself or in the first cycle after release.

Structure
REQ-025 DEBOUNCE_CYCLES and SYNC_STAGES defaults SHALL live in the shared project constants package; no typedefs required.
REQ-026 One sub-module, debounce_channel (synchronizer, counter, level, rise, fall), SHALL be instantiated twice.
REQ-027 Top level SHALL contain only the two instances and port wiring.

Verification (defaults: DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-028 rst=1 for 3 cycles with A_raw=1 -> A=0, all pulses 0 throughout; after release A=1 on 6th edge with A_rise for 1 cycle.
REQ-029 A_raw 0->1 held -> A=1 exactly 6 edges after, A_rise=1 one cycle; later 1->0 held -> A=0 6 edges after, A_fall=1 one cycle.
REQ-030 B_raw high for 3 cycles then low -> B stays 0, B_rise never asserts.
REQ-031 A_raw toggles 1,0,1,0,1 on consecutive cycles then holds 1 -> A rises exactly 6 edges after final 0->1, single A_rise.
REQ-032 A_raw and B_raw rise same cycle -> A and B rise same edge, A_rise and B_rise coincide.
REQ-033 rst pulsed 1 cycle at count 3 of a pending rise -> no change; A rises 6 edges after reset release.
